// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer
// One start pulse walks NUM_DIM frames of IMG_H x IMG_W pixels out of the
// image buffer into con_top. The read for each pixel is issued one cycle
// before the pixel is presented, because rd_data arrives one cycle after
// rd_en. Frames are contiguous in the buffer, so a single incrementing
// pointer replaces the base + dim*N + row*IMG_W + col arithmetic, and
// addresses wrap modulo 2^ADDR_W.
//
// Handshake: start is honoured only in IDLE. abort in any other state
// returns to IDLE on the next edge, and all strobes drop from then on.
// done pulses for one cycle after a run that was not aborted.
//
// Optional feature macro: CONV_SEQ_PERF_EN adds perf_cycles, the number
// of busy cycles of the most recent completed run.
module conv_frame_sequencer #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int IMG_W   = 32,
    parameter int IMG_H   = 35,
    parameter int NUM_DIM = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] ima_out,
    output logic              ena_out,
    output logic              frame_start_out,
    output logic              frame_start_dim_out,
    output logic              line_start_out,
    output logic              frame_end_out,
    output logic              frame_end_dim_out,
    output logic              busy,
    output logic              done
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DIM_W = (NUM_DIM > 1) ? $clog2(NUM_DIM) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [DIM_W-1:0] DIM_LAST = DIM_W'(NUM_DIM - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FSTART = 2'd1,
        PIXEL  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  col_n;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  row_n;
    logic [DIM_W-1:0]  dim;
    logic [DIM_W-1:0]  dim_n;

    // Address of the next read to issue, and the address used this cycle.
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] issue_addr;

    // Values the registered outputs take on the next edge.
    logic              busy_n;
    logic              done_n;
    logic              ena_n;
    logic              fs_n;
    logic              fsd_n;
    logic              ls_n;
    logic              fe_n;
    logic              fed_n;
    logic              rd_en_n;
    logic              last_n;

    // State and pixel-position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            dim   <= '0;
        end else begin
            state <= state_n;
            col   <= col_n;
            row   <= row_n;
            dim   <= dim_n;
        end
    end

    // Next state, next position and the output values for the next cycle.
    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        dim_n   = dim;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = FSTART;
                    col_n   = '0;
                    row_n   = '0;
                    dim_n   = '0;
                end
            end
            FSTART: begin
                state_n = PIXEL;
                col_n   = '0;
                row_n   = '0;
            end
            PIXEL: begin
                if (col == COL_LAST && row == ROW_LAST) begin
                    if (dim == DIM_LAST) begin
                        state_n = DONE;
                    end else begin
                        state_n = FSTART;
                        dim_n   = dim + DIM_W'(1);
                    end
                end else if (col == COL_LAST) begin
                    col_n = '0;
                    row_n = row + ROW_W'(1);
                end else begin
                    col_n = col + COL_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort wins over whatever transition was about to happen.
        if (abort && state != IDLE) begin
            state_n = IDLE;
        end

        busy_n  = 1'b0;
        done_n  = 1'b0;
        ena_n   = 1'b0;
        fs_n    = 1'b0;
        fsd_n   = 1'b0;
        ls_n    = 1'b0;
        fe_n    = 1'b0;
        fed_n   = 1'b0;
        rd_en_n = 1'b0;
        last_n  = (col_n == COL_LAST) && (row_n == ROW_LAST);
        case (state_n)
            FSTART: begin
                busy_n  = 1'b1;
                fs_n    = 1'b1;
                fsd_n   = (dim_n == '0);
                ls_n    = 1'b1;
                rd_en_n = 1'b1;
            end
            PIXEL: begin
                busy_n  = 1'b1;
                ena_n   = 1'b1;
                ls_n    = (col_n == COL_LAST) && (row_n < ROW_LAST);
                fe_n    = last_n;
                fed_n   = last_n && (dim_n == DIM_LAST);
                rd_en_n = !last_n;
            end
            DONE: begin
                done_n = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // A new run reads from cfg_base; otherwise continue from the pointer.
    assign issue_addr = (state == IDLE) ? cfg_base : next_addr;

    // Registered strobes and the buffer read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy                <= 1'b0;
            done                <= 1'b0;
            ena_out             <= 1'b0;
            frame_start_out     <= 1'b0;
            frame_start_dim_out <= 1'b0;
            line_start_out      <= 1'b0;
            frame_end_out       <= 1'b0;
            frame_end_dim_out   <= 1'b0;
            rd_en               <= 1'b0;
            rd_addr             <= '0;
            next_addr           <= '0;
        end else begin
            busy                <= busy_n;
            done                <= done_n;
            ena_out             <= ena_n;
            frame_start_out     <= fs_n;
            frame_start_dim_out <= fsd_n;
            line_start_out      <= ls_n;
            frame_end_out       <= fe_n;
            frame_end_dim_out   <= fed_n;
            rd_en               <= rd_en_n;
            if (rd_en_n) begin
                rd_addr   <= issue_addr;
                next_addr <= issue_addr + ADDR_W'(1);
            end
        end
    end

    // The pixel is the read data of the previous cycle, gated to 0 when idle.
    assign ima_out = ena_out ? rd_data : '0;

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] run_cycles;

    // Count busy cycles of the current run; publish only when it completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cycles  <= '0;
            perf_cycles <= '0;
        end else begin
            if (state == IDLE && start) begin
                run_cycles <= '0;
            end else if (busy) begin
                run_cycles <= run_cycles + 32'd1;
            end
            if (done) begin
                perf_cycles <= run_cycles;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Testbench for conv_frame_sequencer. Expected per-cycle output records are
// pushed when a run is started; a negedge monitor pops one record whenever
// the DUT drives any activity and compares it.
module tb_conv_frame_sequencer;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int IMG_W   = 32;
  localparam int IMG_H   = 35;
  localparam int NUM_DIM = 5;
  localparam int N       = IMG_W * IMG_H;           // 1120
  localparam int RUN_T   = NUM_DIM * (N + 1) + 1;   // 5606, the done cycle
  localparam int W       = 57;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] cfg_base;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] ima_out;
  logic              ena_out;
  logic              frame_start_out;
  logic              frame_start_dim_out;
  logic              line_start_out;
  logic              frame_end_out;
  logic              frame_end_dim_out;
  logic              busy;
  logic              done;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  conv_frame_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_DIM(NUM_DIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .cfg_base(cfg_base),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .ima_out(ima_out),
    .ena_out(ena_out),
    .frame_start_out(frame_start_out),
    .frame_start_dim_out(frame_start_dim_out),
    .line_start_out(line_start_out),
    .frame_end_out(frame_end_out),
    .frame_end_dim_out(frame_end_dim_out),
    .busy(busy),
    .done(done)
`ifdef CONV_SEQ_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  int cyc = 0;
  int run_base = 0;
  int pass_cnt = 0;
  int total_cnt = 0;
  int fs_cnt, fsd_cnt, ls_cnt, fe_cnt, fed_cnt, done_cnt;
  int fsd_rel, fed_rel, done_rel, mon_rel;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_rec;
  logic [W-1:0] exp_rec;

  // ---------------- clock / reset / buffer model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer returns the address that was read, one cycle later.
  initial rd_data = '0;
  always @(posedge clk) if (rd_en) rd_data <= rd_addr;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else if (total_cnt - pass_cnt <= 25)
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc - run_base);
  endtask

  function automatic logic [W-1:0] mk_rec(input int rel, input bit b_busy, input bit b_done,
                                          input bit b_ena, input bit b_fs, input bit b_fsd,
                                          input bit b_ls, input bit b_fe, input bit b_fed,
                                          input bit b_rd, input logic [15:0] addr,
                                          input logic [15:0] ima);
    logic [15:0] rel16;
    logic [15:0] a;
    rel16 = rel[15:0];
    a = b_rd ? addr : 16'h0;
    return {rel16, b_busy, b_done, b_ena, b_fs, b_fsd, b_ls, b_fe, b_fed, b_rd, a, ima};
  endfunction

  // Expected output of every active cycle of a run, cycles 1..min(limit, RUN_T).
  task automatic push_run(input logic [15:0] base, input int limit);
    int j, d, p, k, col, row;
    bit last;
    logic [15:0] fb;
    for (int r = 1; r <= RUN_T && r <= limit; r++) begin
      if (r == RUN_T) begin
        exp_q.push_back(mk_rec(r, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0));
      end else begin
        j  = r - 1;
        d  = j / (N + 1);
        p  = j % (N + 1);
        fb = base + 16'(d * N);
        if (p == 0) begin
          exp_q.push_back(mk_rec(r, 1, 0, 0, 1, d == 0, 1, 0, 0, 1, fb, 16'h0));
        end else begin
          k    = p - 1;
          col  = k % IMG_W;
          row  = k / IMG_W;
          last = (k == N - 1);
          exp_q.push_back(mk_rec(r, 1, 0, 1, 0, 0, (col == IMG_W - 1) && (row < IMG_H - 1),
                                 last, last && (d == NUM_DIM - 1), !last,
                                 fb + 16'(k + 1), fb + 16'(k)));
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [15:0] base, input int limit, input bit with_abort);
    @(negedge clk);
    cfg_base = base;
    start    = 1'b1;
    abort    = with_abort;
    run_base = cyc;
    fs_cnt = 0; fsd_cnt = 0; ls_cnt = 0; fe_cnt = 0; fed_cnt = 0; done_cnt = 0;
    fsd_rel = -1; fed_rel = -1; done_rel = -1;
    push_run(base, limit);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    int g;
    g = 0;
    while ((cyc - run_base) < r && g < 70000) begin
      @(negedge clk);
      g++;
    end
    if ((cyc - run_base) != r) begin
      total_cnt++;
      $display("FAIL wait_rel: reached cycle %0d expected %0d", cyc - run_base, r);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 8000) begin
      @(negedge clk);
      g++;
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_idle(input string name, input bit with_addr);
    chk(name, {busy, done, ena_out, frame_start_out, frame_start_dim_out, line_start_out,
               frame_end_out, frame_end_dim_out, rd_en, with_addr ? rd_addr : 16'h0, ima_out},
        64'd0);
  endtask

  task automatic chk_full_run();
    chk("frame_start_count", 64'(fs_cnt), 64'd5);
    chk("frame_end_count", 64'(fe_cnt), 64'd5);
    chk("line_start_count", 64'(ls_cnt), 64'd175);
    chk("frame_start_dim_count", 64'(fsd_cnt), 64'd1);
    chk("frame_end_dim_count", 64'(fed_cnt), 64'd1);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("frame_start_dim_cycle", 64'(fsd_rel), 64'd1);
    chk("frame_end_dim_cycle", 64'(fed_rel), 64'd5605);
    chk("done_cycle", 64'(done_rel), 64'd5606);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && (busy | done | ena_out | frame_start_out | frame_start_dim_out |
                 line_start_out | frame_end_out | frame_end_dim_out | rd_en)) begin
      mon_rel = cyc - run_base;
      if (frame_start_out) fs_cnt++;
      if (frame_end_out) fe_cnt++;
      if (line_start_out) ls_cnt++;
      if (frame_start_dim_out) begin fsd_cnt++; fsd_rel = mon_rel; end
      if (frame_end_dim_out) begin fed_cnt++; fed_rel = mon_rel; end
      if (done) begin done_cnt++; done_rel = mon_rel; end
      act_rec = mk_rec(mon_rel, busy, done, ena_out, frame_start_out, frame_start_dim_out,
                       line_start_out, frame_end_out, frame_end_dim_out, rd_en, rd_addr, ima_out);
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(act_rec), 64'd0);
      end else begin
        exp_rec = exp_q.pop_front();
        chk("stream_record", 64'(act_rec), 64'(exp_rec));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    cfg_base = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset_outputs", 1'b1);
`ifdef CONV_SEQ_PERF_EN
    chk("perf_reset", 64'(perf_cycles), 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Full run from base 0: pixels 0..5599.
    start_run(16'h0000, RUN_T, 1'b0);
    drain();
    chk_full_run();
`ifdef CONV_SEQ_PERF_EN
    chk("perf_full_run", 64'(perf_cycles), 64'd5605);
`endif

    // Back-to-back run from 0xFF00 (wraps), with ignored starts at 10 and 3000.
    start_run(16'hFF00, RUN_T, 1'b0);
    wait_rel(10);
    cfg_base = 16'h0AAA;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rel(3000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    chk_full_run();

    // Abort at cycle 1500, then restart at 1502 with abort held alongside start.
    start_run(16'h0000, 1500, 1'b0);
    wait_rel(1500);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle("abort_outputs", 1'b0);
    chk("abort_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef CONV_SEQ_PERF_EN
    chk("perf_after_abort", 64'(perf_cycles), 64'd5605);
`endif
    start_run(16'h1234, RUN_T, 1'b1);
    drain();
    chk_full_run();

    // Asynchronous reset at cycle 2000, then a clean run.
    start_run(16'h0100, 1999, 1'b0);
    wait_rel(1999);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_idle("rst_async_outputs", 1'b1);
    chk("rst_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef CONV_SEQ_PERF_EN
    chk("perf_after_rst", 64'(perf_cycles), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_run(16'h0000, RUN_T, 1'b0);
    drain();
    chk_full_run();
`ifdef CONV_SEQ_PERF_EN
    chk("perf_after_rst_run", 64'(perf_cycles), 64'd5605);
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
